// File: rtl/wb_arbiter2_pkg.sv
// Shared definitions for the two-master Wishbone arbiter: grant state
// encoding, watchdog sizing and the default abort limit.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_t;

  localparam int TIMEOUT_DEFAULT = 255;
  localparam int CNT_W           = 8;

  function automatic arb_state_t gnt_state(input logic master);
    return master ? GNT1 : GNT0;
  endfunction

endpackage

// File: rtl/wb_arbiter2_if.sv
// One Wishbone point-to-point link. The bus owner uses the master modport,
// the responder uses the slave modport; err only flows towards the master.
interface wb_arbiter2_if;

  logic [31:0] adr;
  logic [31:0] dat_w;
  logic [31:0] dat_r;
  logic        we;
  logic [3:0]  sel;
  logic        cyc;
  logic        stb;
  logic        ack;
  logic        err;

  modport master (output adr, dat_w, we, sel, cyc, stb, input dat_r, ack);
  modport slave  (input adr, dat_w, we, sel, cyc, stb, output dat_r, ack, err);

endinterface

// File: rtl/wb_arbiter2_watchdog.sv
// Saturating wait counter for the granted strobe; expired flags the abort
// cycle once TIMEOUT-1 unacknowledged cycles have elapsed.
module wb_arb_watchdog
  import wb_arb_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic clr,
  output logic expired
);

  localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (run && cnt_reg != CNT_MAX) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign expired = (cnt_reg == LIMIT);

endmodule

// File: rtl/wb_arbiter2.sv
// Two-master Wishbone arbiter: alternating priority on ties, locked multi-beat
// cycles, and a watchdog that aborts a strobe the slave never acknowledges.
module wb_arbiter2
  import wb_arb_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  wb_arbiter2_if.slave  m0,
  wb_arbiter2_if.slave  m1,
  wb_arbiter2_if.master s
);

  arb_state_t  state_reg;
  arb_state_t  state_next;
  logic        last_r;

  logic        granted;
  logic        sel1;
  logic [31:0] g_adr;
  logic [31:0] g_dat;
  logic        g_we;
  logic [3:0]  g_sel;
  logic        g_cyc;
  logic        g_stb;
  logic        expired;
  logic        abort;
  logic        hold;
  logic        wd_run;
  logic        wd_clr;

  // Routing is driven by the registered grant only, never by the requests.
  assign granted = (state_reg != IDLE);
  assign sel1    = (state_reg == GNT1);
  assign g_adr   = sel1 ? m1.adr   : m0.adr;
  assign g_dat   = sel1 ? m1.dat_w : m0.dat_w;
  assign g_we    = sel1 ? m1.we    : m0.we;
  assign g_sel   = sel1 ? m1.sel   : m0.sel;
  assign g_cyc   = sel1 ? m1.cyc   : m0.cyc;
  assign g_stb   = sel1 ? m1.stb   : m0.stb;

  // A coincident ack beats the timeout.
  assign abort = granted & g_stb & expired & ~s.ack;
  assign hold  = g_cyc & ~abort;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (m0.cyc && m1.cyc) state_next = gnt_state(~last_r);
        else if (m0.cyc)      state_next = GNT0;
        else if (m1.cyc)      state_next = GNT1;
      end
      GNT0:    if (!hold) state_next = m1.cyc ? GNT1 : IDLE;
      GNT1:    if (!hold) state_next = m0.cyc ? GNT0 : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      last_r    <= 1'b1;
    end else begin
      state_reg <= state_next;
      if (state_next != IDLE) last_r <= (state_next == GNT1);
    end
  end

  assign wd_run = granted & g_stb & ~s.ack;
  assign wd_clr = ~(granted & g_stb) | s.ack | (state_next != state_reg);

  wb_arb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .run    (wd_run),
    .clr    (wd_clr),
    .expired(expired)
  );

  assign s.adr   = granted ? g_adr : 32'h0;
  assign s.dat_w = granted ? g_dat : 32'h0;
  assign s.we    = granted & g_we;
  assign s.sel   = granted ? g_sel : 4'h0;
  assign s.cyc   = granted & g_cyc & ~abort;
  assign s.stb   = granted & g_stb & ~abort;

  assign m0.dat_r = s.dat_r;
  assign m1.dat_r = s.dat_r;
  assign m0.ack   = s.ack & (state_reg == GNT0) & ~abort;
  assign m1.ack   = s.ack & (state_reg == GNT1) & ~abort;
  assign m0.err   = abort & (state_reg == GNT0);
  assign m1.err   = abort & (state_reg == GNT1);

endmodule

// File: tb/tb_wb_arbiter2.sv
// Self-checking bench for wb_arbiter2: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a model.
module tb_wb_arbiter2;

  localparam int TO = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wb_arbiter2_if bm0 ();
  wb_arbiter2_if bm1 ();
  wb_arbiter2_if bs ();

  wb_arbiter2 #(.TIMEOUT(TO)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .m0   (bm0),
    .m1   (bm1),
    .s    (bs)
  );

  int n_checks = 0;
  int n_errors = 0;
  int sl_wait  = 0;

  // Model state: current bus owner (-1 none), last owner, cycles waited.
  int mdl_owner = -1;
  int mdl_last  = 1;
  int mdl_wait  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [138:0] act_v;
    logic [138:0] exp_v;
    int           o;
    int           nx;
    logic         gcyc, gstb, to_hit;
    logic [31:0]  e_adr, e_dat;
    logic         e_we;
    logic [3:0]   e_sel;

    if (!rst_n) begin
      mdl_owner = -1;
      mdl_last  = 1;
      mdl_wait  = 0;
    end
    o      = mdl_owner;
    gcyc   = (o == 0) ? bm0.cyc : (o == 1) ? bm1.cyc : 1'b0;
    gstb   = (o == 0) ? bm0.stb : (o == 1) ? bm1.stb : 1'b0;
    to_hit = (o >= 0) && gstb && !bs.ack && (mdl_wait == TO - 1);
    e_adr  = (o == 0) ? bm0.adr   : (o == 1) ? bm1.adr   : 32'h0;
    e_dat  = (o == 0) ? bm0.dat_w : (o == 1) ? bm1.dat_w : 32'h0;
    e_we   = (o == 0) ? bm0.we    : (o == 1) ? bm1.we    : 1'b0;
    e_sel  = (o == 0) ? bm0.sel   : (o == 1) ? bm1.sel   : 4'h0;

    act_v = {bs.adr, bs.dat_w, bs.we, bs.sel, bs.cyc, bs.stb,
             bm0.ack, bm0.err, bm1.ack, bm1.err, bm0.dat_r, bm1.dat_r};
    exp_v = {e_adr, e_dat, e_we, e_sel, gcyc && !to_hit, gstb && !to_hit,
             bs.ack && o == 0 && !to_hit, to_hit && o == 0,
             bs.ack && o == 1 && !to_hit, to_hit && o == 1,
             bs.dat_r, bs.dat_r};
    n_checks++;
    if (act_v !== exp_v) begin
      n_errors++;
      $display("FAIL cycle_outputs at %0t: got %h expected %h", $time, act_v, exp_v);
    end

    if (rst_n) begin
      if (o < 0) begin
        if (bm0.cyc && bm1.cyc) nx = (mdl_last == 0) ? 1 : 0;
        else if (bm0.cyc)       nx = 0;
        else if (bm1.cyc)       nx = 1;
        else                    nx = -1;
      end else if (gcyc && !to_hit) begin
        nx = o;
      end else begin
        nx = ((o == 0 ? bm1.cyc : bm0.cyc)) ? 1 - o : -1;
      end
      if (nx != o || o < 0 || !gstb || bs.ack) mdl_wait = 0;
      else if (mdl_wait < 255)                 mdl_wait = mdl_wait + 1;
      if (nx >= 0) mdl_last = nx;
      mdl_owner = nx;
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bm0.adr = '0; bm0.dat_w = '0; bm0.we = 1'b0; bm0.sel = '0; bm0.cyc = 1'b0; bm0.stb = 1'b0;
    bm1.adr = '0; bm1.dat_w = '0; bm1.we = 1'b0; bm1.sel = '0; bm1.cyc = 1'b0; bm1.stb = 1'b0;
    bs.ack = 1'b0; bs.dat_r = '0;
  endtask

  task automatic do_reset();
    nxt();
    rst_n = 1'b0;
    idle_inputs();
    nxt();
    nxt();
    rst_n = 1'b1;
    sl_wait = 0;
  endtask

  // Responsive slave: acks once the strobe has been seen for lat cycles.
  task automatic slave_step(input int lat);
    bs.ack = 1'b0;
    #1;
    if (bs.stb) begin
      if (sl_wait >= lat) begin
        bs.ack = 1'b1;
        sl_wait = 0;
      end else begin
        sl_wait++;
      end
    end else begin
      sl_wait = 0;
    end
  endtask

  initial begin
    int ack_cnt, m0_acks, err_at, err_cnt;
    int order_q[$];
    logic got0, got1;

    idle_inputs();

    // m1 write, slave acks two cycles after the strobe reaches it
    do_reset();
    bm1.adr = 32'h10; bm1.dat_w = 32'hDEADBEEF; bm1.we = 1'b1; bm1.sel = 4'hF;
    bm1.cyc = 1'b1; bm1.stb = 1'b1; bs.dat_r = 32'h12345678;
    ack_cnt = 0; m0_acks = 0;
    for (int c = 0; c < 6; c++) begin
      if (c == 4) begin bm1.cyc = 1'b0; bm1.stb = 1'b0; end
      slave_step(2);
      smp();
      if (bm1.ack) ack_cnt++;
      if (bm0.ack) m0_acks++;
      if (c == 0) check("A_idle_latency", bs.cyc, 0);
      if (c == 1) begin
        check("A_scyc_rise", bs.cyc, 1);
        check("A_sdat", bs.dat_w, 64'hDEADBEEF);
        check("A_sadr", bs.adr, 64'h10);
        check("A_swe", bs.we, 1);
      end
      if (c == 3) begin
        check("A_m1_ack", bm1.ack, 1);
        check("A_rdat", bm1.dat_r, 64'h12345678);
      end
      nxt();
    end
    check("A_ack_pulses", ack_cnt, 1);
    check("A_m0_ack_none", m0_acks, 0);

    // simultaneous requests after reset, m0 first, then m1 without idle
    do_reset();
    bm0.adr = 32'h100; bm0.cyc = 1'b1; bm0.stb = 1'b1;
    bm1.adr = 32'h200; bm1.cyc = 1'b1; bm1.stb = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (c == 2) begin bm0.cyc = 1'b0; bm0.stb = 1'b0; end
      if (c == 4) begin bm1.cyc = 1'b0; bm1.stb = 1'b0; end
      slave_step(0);
      smp();
      if (c == 1) begin
        check("B_first_gnt_adr", bs.adr, 64'h100);
        check("B_m0_ack", bm0.ack, 1);
      end
      if (c == 2) check("B_m1_ack_wait", bm1.ack, 0);
      if (c == 3) begin
        check("B_handover_adr", bs.adr, 64'h200);
        check("B_handover_cyc", bs.cyc, 1);
        check("B_m1_ack", bm1.ack, 1);
      end
      nxt();
    end

    // both masters requesting continuously: grants alternate
    do_reset();
    got0 = 1'b0; got1 = 1'b0;
    bm0.adr = 32'h1000; bm1.adr = 32'h2000;
    for (int c = 0; c < 14; c++) begin
      bm0.cyc = !got0; bm0.stb = !got0;
      bm1.cyc = !got1; bm1.stb = !got1;
      slave_step(0);
      smp();
      if (bm0.ack) order_q.push_back(0);
      if (bm1.ack) order_q.push_back(1);
      got0 = bm0.ack; got1 = bm1.ack;
      nxt();
    end
    for (int k = 0; k < 4; k++)
      check($sformatf("C_order%0d", k), (k < order_q.size()) ? order_q[k] : 99, k % 2);
    idle_inputs();

    // slave never acks m0: abort after TO cycles, pending m1 granted next
    do_reset();
    bm0.adr = 32'h300; bm0.cyc = 1'b1; bm0.stb = 1'b1;
    err_at = -1; err_cnt = 0;
    for (int c = 0; c < 11; c++) begin
      if (c == 2) begin bm1.adr = 32'h400; bm1.cyc = 1'b1; bm1.stb = 1'b1; end
      if (err_at >= 0) begin bm0.cyc = 1'b0; bm0.stb = 1'b0; end
      smp();
      if (bm0.err) begin
        err_cnt++;
        if (err_at < 0) err_at = c;
        check("D_scyc_abort", bs.cyc, 0);
        check("D_sstb_abort", bs.stb, 0);
        check("D_m1_err", bm1.err, 0);
      end
      if (err_at >= 0 && c == err_at + 1) begin
        check("D_m1_gnt_adr", bs.adr, 64'h400);
        check("D_m1_gnt_cyc", bs.cyc, 1);
      end
      nxt();
    end
    check("D_err_cycle", err_at, 8);
    check("D_err_pulses", err_cnt, 1);

    // reset asserted while m1 awaits ack
    do_reset();
    bm1.adr = 32'h500; bm1.dat_w = 32'hA5A5A5A5; bm1.we = 1'b1; bm1.cyc = 1'b1; bm1.stb = 1'b1;
    nxt();
    smp();
    check("E_gnt1_cyc", bs.cyc, 1);
    nxt();
    bm0.adr = 32'h600; bm0.cyc = 1'b1; bm0.stb = 1'b1;
    bs.ack = 1'b1;
    rst_n = 1'b0;
    #1;
    check("E_rst_scyc", bs.cyc, 0);
    check("E_rst_sstb", bs.stb, 0);
    check("E_rst_sadr", bs.adr, 0);
    check("E_rst_sdat", bs.dat_w, 0);
    check("E_rst_m1ack", bm1.ack, 0);
    nxt();
    nxt();
    rst_n = 1'b1;
    bs.ack = 1'b0;
    smp();
    check("E_release_idle", bs.cyc, 0);
    nxt();
    smp();
    check("E_tie_m0_adr", bs.adr, 64'h600);
    check("E_tie_m0_cyc", bs.cyc, 1);
    nxt();
    idle_inputs();

    // ack in the same cycle the watchdog expires
    do_reset();
    bm0.adr = 32'h700; bm0.cyc = 1'b1; bm0.stb = 1'b1;
    err_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      if (c == 9) begin bm0.cyc = 1'b0; bm0.stb = 1'b0; end
      bs.ack = (c == 8);
      smp();
      if (bm0.err) err_cnt++;
      if (c == 8) begin
        check("F_ack_wins", bm0.ack, 1);
        check("F_scyc_kept", bs.cyc, 1);
      end
      nxt();
    end
    check("F_no_err", err_cnt, 0);
    idle_inputs();

    // randomized traffic, checked every cycle by the model
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 5) == 0) bm0.cyc = !bm0.cyc;
      if ($urandom_range(0, 5) == 0) bm1.cyc = !bm1.cyc;
      bm0.stb   = bm0.cyc && ($urandom_range(0, 7) != 0);
      bm1.stb   = bm1.cyc && ($urandom_range(0, 7) != 0);
      bm0.adr   = $urandom; bm0.dat_w = $urandom;
      bm1.adr   = $urandom; bm1.dat_w = $urandom;
      bm0.we    = 1'($urandom_range(0, 1)); bm0.sel = 4'($urandom_range(0, 15));
      bm1.we    = 1'($urandom_range(0, 1)); bm1.sel = 4'($urandom_range(0, 15));
      bs.ack    = ($urandom_range(0, 4) == 0);
      bs.dat_r  = $urandom;
      rst_n     = ($urandom_range(0, 399) != 0);
      nxt();
    end
    rst_n = 1'b1;
    nxt();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
